// File: rtl/qnigma_tcp_sack_sb_if.sv
// SACK scoreboard shared types and the engine-side port bundle.
// Segment SACK option layout and the ACK/hole handshake signals.
package qnigma_tcp_sack_pkg;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } tcp_sack_blk_t;

  typedef struct packed {
    logic [3:0]                val;
    tcp_sack_blk_t [3:0]       blk;
  } tcp_opt_sack_t;

endpackage

interface qnigma_tcp_sack_sb_if;
  import qnigma_tcp_sack_pkg::*;

  logic          ini;
  logic [31:0]   ini_ack;
  logic          upd;
  logic [31:0]   rem_ack;
  tcp_opt_sack_t rem_sack;
  logic          dup_cnd;
  logic [31:0]   snd_nxt;
  logic          hole_req;
  logic [31:0]   una;
  logic          busy;
  logic          hole_done;
  logic          hole_fnd;
  logic [31:0]   hole_start;
  logic [31:0]   hole_stop;
  logic          fast_rtx;
  logic          ovf;

  modport master (
    output ini, ini_ack, upd, rem_ack,
    output rem_sack, dup_cnd, snd_nxt,
    output hole_req,
    input  una, busy, hole_done, hole_fnd,
    input  hole_start, hole_stop,
    input  fast_rtx, ovf
  );

  modport slave (
    input  ini, ini_ack, upd, rem_ack,
    input  rem_sack, dup_cnd, snd_nxt,
    input  hole_req,
    output una, busy, hole_done, hole_fnd,
    output hole_start, hole_stop,
    output fast_rtx, ovf
  );

endinterface

// File: rtl/qnigma_tcp_sack_sb.sv
// Transmit-side SACK scoreboard: tracks snd_una, merges SACK blocks
// into disjoint ranges, counts dup ACKs and hands out retransmit holes.
module qnigma_tcp_sack_sb
  import qnigma_tcp_sack_pkg::*;
#(
  parameter int SB_DEPTH   = 4,
  parameter int DUP_THRESH = 3
) (
  input logic                 clk,
  input logic                 rst,
  qnigma_tcp_sack_sb_if.slave sb
);

  localparam int IW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int DW = $clog2(DUP_THRESH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_TRM,
    S_MRG,
    S_INS,
    S_SCN,
    S_OUT
  } state_t;

  function automatic logic le(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] d;
    d = b - a;
    return !d[31];
  endfunction

  function automatic logic lt(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] d;
    d = a - b;
    return d[31];
  endfunction

  state_t state, state_nxt;

  logic [31:0]   una, hp, ack_q;
  tcp_opt_sack_t sack_q;
  logic          dup_q;
  logic [DW-1:0] dup_cnt;

  logic [31:0]   e_l [SB_DEPTH];
  logic [31:0]   e_r [SB_DEPTH];
  logic [SB_DEPTH-1:0] e_v;

  logic [IW-1:0] idx;
  logic [1:0]    k;
  logic [31:0]   b_l, b_r;
  logic          fnd;
  logic [IW:0]   rty;

  logic [31:0]   hole_start, hole_stop;
  logic          hole_done, hole_fnd;
  logic          fast_rtx, ovf;

  tcp_sack_blk_t cand;
  logic          cand_ok, first, last;
  logic [31:0]   cur_l, cur_r;
  logic          ovl, scn_hit, skip, rty_ok;
  logic          free_ok;
  logic [IW-1:0] free_i;

  always_comb begin
    cand    = sack_q.blk[k];
    cand_ok = sack_q.val[k]
            && lt(cand.left, cand.right)
            && le(una, cand.left)
            && le(cand.right, sb.snd_nxt);
    first   = (idx == '0);
    last    = (idx == IW'(SB_DEPTH - 1));
    // First compare tick works on the raw block, later ones on the union
    cur_l   = first ? cand.left  : b_l;
    cur_r   = first ? cand.right : b_r;
    ovl     = e_v[idx]
            && le(cur_l, e_r[idx])
            && le(e_l[idx], cur_r);
    scn_hit = e_v[idx]
            && le(hp, e_l[idx])
            && (first || !fnd || lt(e_l[idx], b_l));
    skip    = fnd && (b_l == hp);
    rty_ok  = rty < (IW+1)'(SB_DEPTH);
    free_ok = 1'b0;
    free_i  = '0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      if (!e_v[i]) begin
        free_ok = 1'b1;
        free_i  = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (sb.upd)           state_nxt = S_ACK;
        else if (sb.hole_req) state_nxt = S_SCN;
      end
      S_ACK: state_nxt = S_TRM;
      S_TRM: if (last) state_nxt = S_MRG;
      S_MRG: begin
        if (!cand_ok) begin
          if (k == 2'd0) state_nxt = S_IDLE;
        end else if (last) begin
          state_nxt = S_INS;
        end
      end
      S_INS: state_nxt = (k == 2'd0) ? S_IDLE : S_MRG;
      S_SCN: if (last) state_nxt = S_OUT;
      S_OUT: state_nxt = (skip && rty_ok) ? S_SCN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (sb.ini) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      una        <= '0;
      hp         <= '0;
      ack_q      <= '0;
      sack_q     <= '0;
      dup_q      <= 1'b0;
      dup_cnt    <= '0;
      e_v        <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        e_l[i] <= '0;
        e_r[i] <= '0;
      end
      idx        <= '0;
      k          <= '0;
      b_l        <= '0;
      b_r        <= '0;
      fnd        <= 1'b0;
      rty        <= '0;
      hole_start <= '0;
      hole_stop  <= '0;
      hole_done  <= 1'b0;
      hole_fnd   <= 1'b0;
      fast_rtx   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      hole_done <= 1'b0;
      hole_fnd  <= 1'b0;
      fast_rtx  <= 1'b0;
      ovf       <= 1'b0;
      if (sb.ini) begin
        una     <= sb.ini_ack;
        hp      <= sb.ini_ack;
        e_v     <= '0;
        dup_cnt <= '0;
        idx     <= '0;
        rty     <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            idx <= '0;
            rty <= '0;
            if (sb.upd) begin
              ack_q  <= sb.rem_ack;
              sack_q <= sb.rem_sack;
              dup_q  <= sb.dup_cnd;
            end
          end
          S_ACK: begin
            if (lt(una, ack_q) && le(ack_q, sb.snd_nxt)) begin
              una     <= ack_q;
              dup_cnt <= '0;
            end else if (dup_q && ack_q == una
                         && una != sb.snd_nxt
                         && dup_cnt < DW'(DUP_THRESH)) begin
              dup_cnt <= dup_cnt + 1'b1;
              if (dup_cnt == DW'(DUP_THRESH - 1))
                fast_rtx <= 1'b1;
            end
          end
          S_TRM: begin
            if (e_v[idx] && le(e_r[idx], una))
              e_v[idx] <= 1'b0;
            else if (e_v[idx] && lt(e_l[idx], una))
              e_l[idx] <= una;
            idx <= last ? '0 : idx + 1'b1;
            if (last) k <= 2'd3;
          end
          S_MRG: begin
            if (!cand_ok) begin
              if (k == 2'd0) hp <= una;
              else           k  <= k - 1'b1;
            end else begin
              if (ovl) begin
                b_l      <= lt(e_l[idx], cur_l) ? e_l[idx] : cur_l;
                b_r      <= lt(cur_r, e_r[idx]) ? e_r[idx] : cur_r;
                e_v[idx] <= 1'b0;
              end else begin
                b_l <= cur_l;
                b_r <= cur_r;
              end
              idx <= last ? '0 : idx + 1'b1;
            end
          end
          S_INS: begin
            if (free_ok) begin
              e_l[free_i] <= b_l;
              e_r[free_i] <= b_r;
              e_v[free_i] <= 1'b1;
            end else begin
              ovf <= 1'b1;
            end
            if (k == 2'd0) hp <= una;
            else           k  <= k - 1'b1;
            idx <= '0;
          end
          S_SCN: begin
            if (scn_hit) begin
              fnd <= 1'b1;
              b_l <= e_l[idx];
              b_r <= e_r[idx];
            end else if (first) begin
              fnd <= 1'b0;
            end
            idx <= last ? '0 : idx + 1'b1;
          end
          S_OUT: begin
            idx <= '0;
            if (fnd && !skip) begin
              hole_done  <= 1'b1;
              hole_fnd   <= 1'b1;
              hole_start <= hp;
              hole_stop  <= b_l;
              hp         <= b_r;
            end else if (skip) begin
              // Entry starts right at hp: nothing to resend there, look past it
              hp  <= b_r;
              rty <= rty + 1'b1;
              if (!rty_ok) hole_done <= 1'b1;
            end else begin
              hole_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sb.una        = una;
  assign sb.busy       = (state != S_IDLE);
  assign sb.hole_done  = hole_done;
  assign sb.hole_fnd   = hole_fnd;
  assign sb.hole_start = hole_start;
  assign sb.hole_stop  = hole_stop;
  assign sb.fast_rtx   = fast_rtx;
  assign sb.ovf        = ovf;

endmodule

// File: tb/tb_qnigma_tcp_sack_sb.sv
// Directed bench for the SACK scoreboard: ACK tracking, block merge,
// hole search, dup-ACK fast retransmit, wrap, overflow and ini abort.
module tb_qnigma_tcp_sack_sb;
  import qnigma_tcp_sack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  int          rtx_n, ovf_n;
  logic        h_fnd;
  logic [31:0] h_start, h_stop;

  always #5 clk = ~clk;

  qnigma_tcp_sack_sb_if sb ();

  qnigma_tcp_sack_sb #(
    .SB_DEPTH   (4),
    .DUP_THRESH (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic tcp_opt_sack_t sk(
    input logic [3:0]  v,
    input logic [31:0] l0 = 0, r0 = 0,
    input logic [31:0] l1 = 0, r1 = 0,
    input logic [31:0] l2 = 0, r2 = 0,
    input logic [31:0] l3 = 0, r3 = 0
  );
    tcp_opt_sack_t s;
    s = '0;
    s.val = v;
    s.blk[0].left = l0; s.blk[0].right = r0;
    s.blk[1].left = l1; s.blk[1].right = r1;
    s.blk[2].left = l2; s.blk[2].right = r2;
    s.blk[3].left = l3; s.blk[3].right = r3;
    return s;
  endfunction

  task automatic do_ini(input logic [31:0] a, input logic [31:0] nxt);
    @(negedge clk);
    sb.ini     = 1'b1;
    sb.ini_ack = a;
    sb.snd_nxt = nxt;
    @(negedge clk);
    sb.ini = 1'b0;
  endtask

  task automatic do_upd(
    input logic [31:0]   ack,
    input tcp_opt_sack_t s,
    input logic          dup
  );
    logic to;
    @(negedge clk);
    sb.upd      = 1'b1;
    sb.rem_ack  = ack;
    sb.rem_sack = s;
    sb.dup_cnd  = dup;
    @(negedge clk);
    sb.upd = 1'b0;
    rtx_n  = 0;
    ovf_n  = 0;
    to     = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rtx_n += int'(sb.fast_rtx);
      ovf_n += int'(sb.ovf);
      if (!sb.busy) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (to) check("upd_tmo", 32'(to), 32'd0);
  endtask

  task automatic do_hole;
    logic to;
    @(negedge clk);
    sb.hole_req = 1'b1;
    @(negedge clk);
    sb.hole_req = 1'b0;
    to      = 1'b1;
    h_fnd   = 1'b0;
    h_start = '0;
    h_stop  = '0;
    for (int n = 0; n < 100; n++) begin
      if (sb.hole_done) begin
        to      = 1'b0;
        h_fnd   = sb.hole_fnd;
        h_start = sb.hole_start;
        h_stop  = sb.hole_stop;
        break;
      end
      @(negedge clk);
    end
    if (to) check("hole_tmo", 32'(to), 32'd0);
  endtask

  initial begin
    sb.ini      = 1'b0;
    sb.ini_ack  = '0;
    sb.upd      = 1'b0;
    sb.rem_ack  = '0;
    sb.rem_sack = '0;
    sb.dup_cnd  = 1'b0;
    sb.snd_nxt  = '0;
    sb.hole_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_una",   sb.una,                32'd0);
    check("rst_busy",  32'(sb.busy),          32'd0);
    check("rst_hdone", 32'(sb.hole_done),     32'd0);
    check("rst_hfnd",  32'(sb.hole_fnd),      32'd0);
    check("rst_rtx",   32'(sb.fast_rtx),      32'd0);
    check("rst_ovf",   32'(sb.ovf),           32'd0);
    check("rst_hst",   sb.hole_start,         32'd0);
    check("rst_hsp",   sb.hole_stop,          32'd0);

    // single block, first hole
    do_ini(32'd1000, 32'd5000);
    check("ini_una", sb.una, 32'd1000);
    do_upd(32'd1000, sk(4'b0001, 2000, 3000), 1'b0);
    check("u1_una", sb.una, 32'd1000);
    check("u1_ovf", 32'(ovf_n), 32'd0);
    do_hole;
    check("h1_fnd", 32'(h_fnd), 32'd1);
    check("h1_st",  h_start,    32'd1000);
    check("h1_sp",  h_stop,     32'd2000);
    repeat (3) @(negedge clk);
    check("h1_hold", sb.hole_start, 32'd1000);

    // adjacent merge plus a lower block
    do_upd(32'd1000, sk(4'b0011, 3000, 3500, 1500, 1800), 1'b0);
    do_hole;
    check("h2_fnd", 32'(h_fnd), 32'd1);
    check("h2_st",  h_start,    32'd1000);
    check("h2_sp",  h_stop,     32'd1500);
    do_hole;
    check("h3_fnd", 32'(h_fnd), 32'd1);
    check("h3_st",  h_start,    32'd1800);
    check("h3_sp",  h_stop,     32'd2000);
    do_hole;
    check("h4_fnd", 32'(h_fnd), 32'd0);
    check("h4_sp",  sb.hole_stop, 32'd2000);

    // cumulative ACK into an entry trims it
    do_upd(32'd2500, sk(4'b0000), 1'b0);
    check("a_una", sb.una, 32'd2500);
    do_upd(32'd2500, sk(4'b0001, 4000, 4500), 1'b0);
    do_hole;
    check("tr_fnd", 32'(h_fnd), 32'd1);
    check("tr_st",  h_start,    32'd3500);
    check("tr_sp",  h_stop,     32'd4000);

    // out-of-window ACKs are ignored
    do_upd(32'd6000, sk(4'b0000), 1'b0);
    check("ack_hi", sb.una, 32'd2500);
    do_upd(32'd2000, sk(4'b0000), 1'b0);
    check("ack_lo", sb.una, 32'd2500);

    // duplicate ACKs
    do_upd(32'd2500, sk(4'b0000), 1'b1);
    check("dup1", 32'(rtx_n), 32'd0);
    do_upd(32'd2500, sk(4'b0000), 1'b1);
    check("dup2", 32'(rtx_n), 32'd0);
    do_upd(32'd2500, sk(4'b0000), 1'b1);
    check("dup3", 32'(rtx_n), 32'd1);
    do_upd(32'd2500, sk(4'b0000), 1'b1);
    check("dup4", 32'(rtx_n), 32'd0);

    // sequence wrap
    do_ini(32'hFFFF_FF00, 32'h0000_0100);
    do_upd(32'hFFFF_FF00, sk(4'b0001, 32'hFFFF_FFF0, 32'h10), 1'b0);
    do_hole;
    check("w_fnd", 32'(h_fnd), 32'd1);
    check("w_st",  h_start,    32'hFFFF_FF00);
    check("w_sp",  h_stop,     32'hFFFF_FFF0);
    do_upd(32'h20, sk(4'b0000), 1'b0);
    check("w_una", sb.una, 32'h20);
    do_hole;
    check("w_gone", 32'(h_fnd), 32'd0);

    // table overflow and invalid block
    do_ini(32'd1000, 32'd9000);
    do_upd(32'd1000, sk(4'b1111, 2000, 2100, 2200, 2300,
                       2400, 2500, 2600, 2700), 1'b0);
    check("of_4", 32'(ovf_n), 32'd0);
    do_upd(32'd1000, sk(4'b0011, 2800, 2900, 3000, 3000), 1'b0);
    check("of_5", 32'(ovf_n), 32'd1);
    do_hole;
    check("of_fnd", 32'(h_fnd), 32'd1);
    check("of_sp",  h_stop,     32'd2000);

    // ini while merging
    @(negedge clk);
    sb.upd      = 1'b1;
    sb.rem_ack  = 32'd1000;
    sb.rem_sack = sk(4'b0001, 5000, 5100);
    sb.dup_cnd  = 1'b0;
    @(negedge clk);
    sb.upd = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(sb.busy), 32'd1);
    do_ini(32'd1200, 32'd9000);
    check("ab_busy", 32'(sb.busy), 32'd0);
    check("ab_una",  sb.una,       32'd1200);
    do_hole;
    check("ab_fnd", 32'(h_fnd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
